// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data RAM behind valid/ready request and
// response channels, with LATENCY wait states and one transaction in flight.
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   req_valid / req_ready      request handshake (ready only while idle)
//   req_we, req_addr,          store flag, byte address,
//   req_wdata, req_size,       right-aligned store data, 00 byte/01 half/10 word,
//   req_unsigned               zero-extend loads when set
//   resp_valid / resp_ready    response handshake
//   resp_rdata, resp_err       extended load data (0 for stores/errors), error flag
module dmem_responder #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err
);

    localparam int IW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} stateT;

    stateT           state;
    logic [3:0]      waitCnt;
    logic            weQ;
    logic [XLEN-1:0] addrQ;
    logic [XLEN-1:0] wdataQ;
    logic [1:0]      sizeQ;
    logic            unsQ;

    logic            accept;
    logic            commit;
    logic            opWe;
    logic [XLEN-1:0] opAddr;
    logic [XLEN-1:0] opWdata;
    logic [1:0]      opSize;
    logic            opUns;
    logic            opErr;
    logic [IW-1:0]   wordIdx;
    logic [XLEN-1:0] ramWord;
    logic [7:0]      loadByte;
    logic [15:0]     loadHalf;
    logic [XLEN-1:0] loadData;
    logic [3:0]      laneEn;
    logic [XLEN-1:0] laneData;
    logic [XLEN-1:0] respData;

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && (state == IDLE);

    // With no wait states the commit happens on the accept edge, so the
    // operation is taken straight from the request pins.
    always_comb begin
        if (LATENCY == 0) begin
            commit  = accept;
            opWe    = req_we;
            opAddr  = req_addr;
            opWdata = req_wdata;
            opSize  = req_size;
            opUns   = req_unsigned;
        end else begin
            commit  = (state == BUSY) && (waitCnt == 4'd1);
            opWe    = weQ;
            opAddr  = addrQ;
            opWdata = wdataQ;
            opSize  = sizeQ;
            opUns   = unsQ;
        end
    end

    always_comb begin
        opErr = (opAddr[XLEN-1:2] >= (XLEN-2)'(DEPTH_WORDS));
        unique case (opSize)
            2'b00:   opErr = opErr;
            2'b01:   opErr = opErr || opAddr[0];
            2'b10:   opErr = opErr || (opAddr[1:0] != 2'b00);
            default: opErr = 1'b1;
        endcase
    end

    assign wordIdx = opAddr[IW+1:2];
    assign ramWord = mem[wordIdx];

    always_comb begin
        loadByte = ramWord[{opAddr[1:0], 3'b000} +: 8];
        loadHalf = ramWord[{opAddr[1], 4'b0000} +: 16];
        unique case (opSize)
            2'b00:   loadData = {{(XLEN-8){~opUns & loadByte[7]}}, loadByte};
            2'b01:   loadData = {{(XLEN-16){~opUns & loadHalf[15]}}, loadHalf};
            default: loadData = ramWord;
        endcase
        respData = (opErr || opWe) ? '0 : loadData;
    end

    // Narrow stores replicate the data across the word; lane enables pick.
    always_comb begin
        unique case (opSize)
            2'b00: begin
                laneEn   = 4'b0001 << opAddr[1:0];
                laneData = {4{opWdata[7:0]}};
            end
            2'b01: begin
                laneEn   = opAddr[1] ? 4'b1100 : 4'b0011;
                laneData = {2{opWdata[15:0]}};
            end
            default: begin
                laneEn   = 4'b1111;
                laneData = opWdata;
            end
        endcase
    end

    // Reset on the commit edge drops the store.
    always_ff @(posedge clk) begin
        if (!reset && commit && opWe && !opErr) begin
            for (int i = 0; i < 4; i++) begin
                if (laneEn[i]) mem[wordIdx][8*i +: 8] <= laneData[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            weQ    <= req_we;
            addrQ  <= req_addr;
            wdataQ <= req_wdata;
            sizeQ  <= req_size;
            unsQ   <= req_unsigned;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            waitCnt    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (LATENCY == 0) begin
                            state      <= RESP;
                            resp_rdata <= respData;
                            resp_err   <= opErr;
                        end else begin
                            state   <= BUSY;
                            waitCnt <= 4'(LATENCY);
                        end
                    end
                end
                BUSY: begin
                    waitCnt <= waitCnt - 4'd1;
                    if (waitCnt == 4'd1) begin
                        state      <= RESP;
                        resp_rdata <= respData;
                        resp_err   <= opErr;
                    end
                end
                RESP: begin
                    if (resp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: drives a LATENCY=2 and a LATENCY=0 responder with
// directed and random traffic, checked against a byte-array memory model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_size = 2'b10;
    logic        req_unsigned = 1'b0;
    logic        resp_ready = 1'b0;
    logic        en0 = 1'b1;
    logic        req_valid0;

    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        req_ready0, resp_valid0, resp_err0;
    logic [31:0] resp_rdata0;

    int          nChecks = 0;
    int          nFails = 0;

    logic [7:0]  refMem [4096];

    int          obsLat, obsLat0;
    logic [31:0] obsRd, obsRd0;
    logic        obsErr, obsErr0;

    assign req_valid0 = req_valid & en0;

    always #5 clk = ~clk;

    dmem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid0), .req_ready(req_ready0),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .resp_valid(resp_valid0), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata0), .resp_err(resp_err0)
    );

    // Byte-addressed little-endian reference memory.
    function automatic void refOp(input logic we, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [1:0] sz,
                                  input logic un, output logic [31:0] rd,
                                  output logic er);
        int     nb;
        longint v;
        nb = 1 << sz;
        er = (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
             (sz == 2'd2 && a[1:0] != 2'd0) || (a >= 32'd4096);
        rd = '0;
        if (!er) begin
            if (we) begin
                for (int i = 0; i < nb; i++) refMem[a + i] = wd[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < nb; i++)
                    v += longint'(refMem[a + i]) << (8 * i);
                if (!un && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
                    v -= longint'(1) << (8 * nb);
                rd = v[31:0];
            end
        end
    endfunction

    // Issue one request, record latency/response of both DUTs, then take it.
    task automatic txn(input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [1:0] sz,
                       input logic un);
        @(negedge clk);
        req_we = we; req_addr = a; req_wdata = wd;
        req_size = sz; req_unsigned = un; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr = $urandom; req_wdata = $urandom;
        req_size = 2'($urandom); req_we = 1'($urandom);
        obsLat = -1; obsLat0 = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (en0 && resp_valid0 && obsLat0 < 0) begin
                obsLat0 = n; obsRd0 = resp_rdata0; obsErr0 = resp_err0;
            end
            if (resp_valid && obsLat < 0) begin
                obsLat = n; obsRd = resp_rdata; obsErr = resp_err;
            end
            if (obsLat >= 0 && (obsLat0 >= 0 || !en0)) break;
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nChecks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 ||
            resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            nFails++;
            $display("FAIL reset lat2 got rdy=%b vld=%b rd=%h err=%b want 1 0 0 0",
                     req_ready, resp_valid, resp_rdata, resp_err);
        end
        nChecks++;
        if (req_ready0 !== 1'b1 || resp_valid0 !== 1'b0 ||
            resp_rdata0 !== 32'h0 || resp_err0 !== 1'b0) begin
            nFails++;
            $display("FAIL reset lat0 got rdy=%b vld=%b rd=%h err=%b want 1 0 0 0",
                     req_ready0, resp_valid0, resp_rdata0, resp_err0);
        end
        reset = 1'b0;
    endtask

    // Directed table: we, addr, wdata, size, unsigned, expected rdata, err.
    task automatic runTable(input string name, input logic [31:0] t [][7]);
        logic [31:0] dr;
        logic        de;
        foreach (t[k]) begin
            refOp(t[k][0][0], t[k][1], t[k][2], t[k][3][1:0], t[k][4][0], dr, de);
            txn(t[k][0][0], t[k][1], t[k][2], t[k][3][1:0], t[k][4][0]);
            nChecks++;
            if (obsLat !== 3 || obsRd !== t[k][5] || obsErr !== t[k][6][0]) begin
                nFails++;
                $display("FAIL %s[%0d] lat2 got lat=%0d rd=%h err=%b want 3 %h %b",
                         name, k, obsLat, obsRd, obsErr, t[k][5], t[k][6][0]);
            end
            nChecks++;
            if (obsLat0 !== 1 || obsRd0 !== t[k][5] || obsErr0 !== t[k][6][0]) begin
                nFails++;
                $display("FAIL %s[%0d] lat0 got lat=%0d rd=%h err=%b want 1 %h %b",
                         name, k, obsLat0, obsRd0, obsErr0, t[k][5], t[k][6][0]);
            end
        end
    endtask

    task automatic test_word;
        logic [31:0] t [][7];
        t = new[2];
        t[0] = '{1, 32'h10, 32'hDEADBEEF, 2, 0, 32'h0, 0};
        t[1] = '{0, 32'h10, 32'h0,        2, 0, 32'hDEADBEEF, 0};
        runTable("word", t);
    endtask

    task automatic test_lanes;
        logic [31:0] t [][7];
        t = new[7];
        t[0] = '{1, 32'h10, 32'h11223344, 2, 0, 32'h0, 0};
        t[1] = '{1, 32'h13, 32'hAAAAAA80, 0, 0, 32'h0, 0};
        t[2] = '{0, 32'h13, 32'h0, 0, 0, 32'hFFFFFF80, 0};
        t[3] = '{0, 32'h13, 32'h0, 0, 1, 32'h00000080, 0};
        t[4] = '{0, 32'h10, 32'h0, 2, 0, 32'h80223344, 0};
        t[5] = '{0, 32'h12, 32'h0, 1, 0, 32'hFFFF8022, 0};
        t[6] = '{0, 32'h10, 32'h0, 1, 1, 32'h00003344, 0};
        runTable("lanes", t);
    endtask

    task automatic test_errors;
        logic [31:0] t [][7];
        t = new[6];
        t[0] = '{0, 32'h11,   32'h0, 1, 0, 32'h0, 1};
        t[1] = '{1, 32'h12,   32'h12345678, 2, 0, 32'h0, 1};
        t[2] = '{0, 32'h10,   32'h0, 2, 0, 32'h80223344, 0};
        t[3] = '{0, 32'h1000, 32'h0, 2, 0, 32'h0, 1};
        t[4] = '{1, 32'h1000, 32'h5, 0, 0, 32'h0, 1};
        t[5] = '{0, 32'h10,   32'h0, 3, 0, 32'h0, 1};
        runTable("err", t);
    endtask

    task automatic test_backpressure;
        logic [31:0] hold, dr;
        logic        de;
        int          got;
        en0 = 1'b0;
        refOp(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, dr, de);
        @(negedge clk);
        req_we = 1'b0; req_addr = 32'h10; req_size = 2'd2; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        got = 0;
        for (int n = 0; n < 20 && got == 0; n++) begin
            @(negedge clk);
            if (resp_valid) got = 1;
        end
        hold = resp_rdata;
        nChecks++;
        if (got != 1 || hold !== dr) begin
            nFails++;
            $display("FAIL bp_first got vld=%0d rd=%h want 1 %h", got, hold, dr);
        end
        req_we = 1'b1; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            nChecks++;
            if (resp_valid !== 1'b1 || resp_rdata !== hold || req_ready !== 1'b0) begin
                nFails++;
                $display("FAIL bp_hold[%0d] got vld=%b rd=%h rdy=%b want 1 %h 0",
                         n, resp_valid, resp_rdata, req_ready, hold);
            end
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        en0 = 1'b1;
        refOp(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, dr, de);
        txn(1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
        nChecks++;
        if (obsRd !== dr || obsLat !== 3) begin
            nFails++;
            $display("FAIL bp_ignored got rd=%h lat=%0d want %h 3", obsRd, obsLat, dr);
        end
    endtask

    task automatic test_reset_busy;
        logic [31:0] dr;
        logic        de;
        refOp(1'b1, 32'h20, 32'h01020304, 2'd2, 1'b0, dr, de);
        txn(1'b1, 32'h20, 32'h01020304, 2'd2, 1'b0);
        en0 = 1'b0;
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h55AA55AA;
        req_size = 2'd2; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        nChecks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            nFails++;
            $display("FAIL rst_busy got rdy=%b vld=%b want 1 0", req_ready, resp_valid);
        end
        reset = 1'b0;
        en0 = 1'b1;
        refOp(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, dr, de);
        txn(1'b0, 32'h20, 32'h0, 2'd2, 1'b0);
        nChecks++;
        if (obsRd !== 32'h01020304 || obsErr !== 1'b0) begin
            nFails++;
            $display("FAIL rst_busy_data got rd=%h err=%b want 01020304 0", obsRd, obsErr);
        end
    endtask

    task automatic test_random;
        logic [31:0] a, wd, dr;
        logic [1:0]  sz;
        logic        we, un, de;
        for (int k = 0; k < 64 + 150; k++) begin
            if (k < 64) begin
                we = 1'b1; a = 32'(k * 4); sz = 2'd2; un = 1'b0;
            end else begin
                we = 1'($urandom); un = 1'($urandom);
                sz = 2'($urandom);
                a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 255));
            end
            wd = $urandom;
            refOp(we, a, wd, sz, un, dr, de);
            txn(we, a, wd, sz, un);
            nChecks++;
            if (obsLat !== 3 || obsRd !== dr || obsErr !== de) begin
                nFails++;
                $display("FAIL rand[%0d] lat2 a=%h sz=%0d we=%b got lat=%0d rd=%h err=%b want 3 %h %b",
                         k, a, sz, we, obsLat, obsRd, obsErr, dr, de);
            end
            nChecks++;
            if (obsLat0 !== 1 || obsRd0 !== dr || obsErr0 !== de) begin
                nFails++;
                $display("FAIL rand[%0d] lat0 a=%h sz=%0d we=%b got lat=%0d rd=%h err=%b want 1 %h %b",
                         k, a, sz, we, obsLat0, obsRd0, obsErr0, dr, de);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_word();
        test_lanes();
        test_errors();
        test_backpressure();
        test_reset_busy();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
